// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the 640x480@60 VGA timing generator.
//   - default horizontal/vertical timing (pixels / lines) and totals
//   - region boundaries (sync start/end) for the default timing
//   - rgb12_t: 12-bit colour as {r,g,b}, 4 bits each
//   - test_bar_colour(): colour of each of the eight vertical test bars
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int CNT_W          = 10;

   localparam int H_ACTIVE_DEF   = 640;
   localparam int H_FP_DEF       = 16;
   localparam int H_SYNC_DEF     = 96;
   localparam int H_BP_DEF       = 48;
   localparam int H_TOTAL_DEF    = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

   localparam int V_ACTIVE_DEF   = 480;
   localparam int V_FP_DEF       = 10;
   localparam int V_SYNC_DEF     = 2;
   localparam int V_BP_DEF       = 33;
   localparam int V_TOTAL_DEF    = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
   localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

   localparam int   CLK_DIV_DEF  = 4;
   localparam logic SYNC_ACT_DEF = 1'b0;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb12_t;

   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic rgb12_t test_bar_colour(input logic [2:0] bar);
      rgb12_t c;
      case (bar)
         3'd0:    c = '{r: 4'hF, g: 4'hF, b: 4'hF};
         3'd1:    c = '{r: 4'hF, g: 4'hF, b: 4'h0};
         3'd2:    c = '{r: 4'h0, g: 4'hF, b: 4'hF};
         3'd3:    c = '{r: 4'h0, g: 4'hF, b: 4'h0};
         3'd4:    c = '{r: 4'hF, g: 4'h0, b: 4'hF};
         3'd5:    c = '{r: 4'hF, g: 4'h0, b: 4'h0};
         3'd6:    c = '{r: 4'h0, g: 4'h0, b: 4'hF};
         default: c = '{r: 4'h0, g: 4'h0, b: 4'h0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_gen.sv
// -----------------------------------------------------------------------------
// pix_en_gen
// Free-running divide-by-CLK_DIV counter producing a one-cycle pixel enable.
// Pixel logic stays on CLK100MHZ and advances only when pix_en_o is high, so
// no derived clock is ever created. Reusable by any pixel source that needs
// the same enable phase.
//   CLK100MHZ   in   system clock
//   CPU_RESETN  in   asynchronous active-low reset
//   pix_en_o    out  high in the cycle where the divider sits at CLK_DIV-1
// Parameter CLK_DIV (>= 2): system clocks per pixel.
// -----------------------------------------------------------------------------
module pix_en_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic CLK100MHZ,
   input  logic CPU_RESETN,
   output logic pix_en_o
);

   localparam int              DIV_W    = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;

   always_comb begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      // Registered strobe: high exactly while div_q holds DIV_LAST.
      pix_en_d = (div_d == DIV_LAST);
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         div_q    <= '0;
         pix_en_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         pix_en_q <= pix_en_d;
      end
   end

   assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480@60 VGA timing generator and registered pixel output stage.
// Publishes the current pixel coordinate to the upstream source, takes the
// source's 12-bit colour back and drives blanked, sync-aligned RGB/HS/VS.
// Pins show counter state (h,v) one pixel after x/y show it.
//   CLK100MHZ    in   system clock (100 MHz)
//   CPU_RESETN   in   asynchronous active-low reset
//   rgb_in       in   {R,G,B} colour for the current (x,y)
//   test_en      in   select built-in colour bars (VGA_TEST_PATTERN_EN builds)
//   pix_en       out  one-cycle pixel enable every CLK_DIV clocks
//   x, y         out  current horizontal / vertical count
//   active       out  (x,y) inside the visible area (combinational)
//   line_start   out  pix_en && x==0
//   frame_start  out  pix_en && x==0 && y==0
//   VGA_R/G/B    out  registered colour, forced to 0 outside the visible area
//   VGA_HS/VS    out  registered syncs, asserted level SYNC_ACT
// Build option: define VGA_TEST_PATTERN_EN to include the eight-bar test
// pattern; without it test_en is ignored and no pattern logic is built.
// -----------------------------------------------------------------------------
import vga_pkg::*;

module vga_timing_gen #(
   parameter int   H_ACTIVE = H_ACTIVE_DEF,
   parameter int   H_FP     = H_FP_DEF,
   parameter int   H_SYNC   = H_SYNC_DEF,
   parameter int   H_BP     = H_BP_DEF,
   parameter int   V_ACTIVE = V_ACTIVE_DEF,
   parameter int   V_FP     = V_FP_DEF,
   parameter int   V_SYNC   = V_SYNC_DEF,
   parameter int   V_BP     = V_BP_DEF,
   parameter int   CLK_DIV  = CLK_DIV_DEF,
   parameter logic SYNC_ACT = SYNC_ACT_DEF
) (
   input  logic             CLK100MHZ,
   input  logic             CPU_RESETN,
   input  logic [11:0]      rgb_in,
   input  logic             test_en,
   output logic             pix_en,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             active,
   output logic             line_start,
   output logic             frame_start,
   output logic [3:0]       VGA_R,
   output logic [3:0]       VGA_G,
   output logic [3:0]       VGA_B,
   output logic             VGA_HS,
   output logic             VGA_VS
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   rgb12_t           rgb_q, rgb_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;

   logic             in_hsync, in_vsync;
   rgb12_t           src_rgb;

   pix_en_gen #(
      .CLK_DIV    (CLK_DIV)
   ) u_pix_en_gen (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .pix_en_o   (pix_en)
   );

   // ---------------------------------------------------------------- counters
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign x           = h_q;
   assign y           = v_q;
   assign active      = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
   assign line_start  = pix_en && (h_q == '0);
   assign frame_start = pix_en && (h_q == '0) && (v_q == '0);

   // ----------------------------------------------------------- region decode
   assign in_hsync = (h_q >= CNT_W'(H_SYNC_START)) && (h_q < CNT_W'(H_SYNC_END));
   assign in_vsync = (v_q >= CNT_W'(V_SYNC_START)) && (v_q < CNT_W'(V_SYNC_END));

   // ---------------------------------------------------------- colour source
`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;

   logic [2:0] bar;

   // Bar index by threshold count avoids a divider on h_q.
   always_comb begin
      bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (h_q >= CNT_W'(i * BAR_W)) bar = bar + 3'd1;
      end
   end

   assign src_rgb = test_en ? test_bar_colour(bar) : rgb12_t'(rgb_in);
`else
   logic unused_test_en;
   assign unused_test_en = test_en;
   assign src_rgb        = rgb12_t'(rgb_in);
`endif

   // ------------------------------------------------------------ output stage
   // Colour and syncs are captured on the same pix_en from the same (h,v),
   // so they stay mutually aligned; blanking is applied here unconditionally.
   always_comb begin
      rgb_d = active ? src_rgb : '0;
      hs_d  = in_hsync ? SYNC_ACT : ~SYNC_ACT;
      vs_d  = in_vsync ? SYNC_ACT : ~SYNC_ACT;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         rgb_q <= '0;
         hs_q  <= ~SYNC_ACT;
         vs_q  <= ~SYNC_ACT;
      end else if (pix_en) begin
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end

   assign VGA_R  = rgb_q.r;
   assign VGA_G  = rgb_q.g;
   assign VGA_B  = rgb_q.b;
   assign VGA_HS = hs_q;
   assign VGA_VS = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Horizontal timing is the real 640/16/96/48; the vertical timing is shrunk
// (3 active, 1 FP, 2 sync, 1 BP = 7 lines) so two whole frames fit in a
// short run. Expected values come from the absolute clock count since reset
// release (n): pixel k = n/4, h = k%800, v = (k/800)%7; pins show pixel k-1.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int VA   = 3;
   localparam int VFP  = 1;
   localparam int VSW  = 2;
   localparam int VBP  = 1;
   localparam int VT   = VA + VFP + VSW + VBP;
   localparam int HT   = 800;
   localparam int LINE_CLKS  = 3200;
   localparam int FRAME_CLKS = LINE_CLKS * VT;

   logic        CLK100MHZ = 1'b0;
   logic        CPU_RESETN = 1'b0;
   logic [11:0] rgb_in = 12'h000;
   logic        test_en = 1'b0;
   logic        pix_en, active, line_start, frame_start;
   logic [9:0]  x, y;
   logic [3:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS;

   vga_timing_gen #(
      .V_ACTIVE (VA),
      .V_FP     (VFP),
      .V_SYNC   (VSW),
      .V_BP     (VBP)
   ) dut (
      .CLK100MHZ   (CLK100MHZ),
      .CPU_RESETN  (CPU_RESETN),
      .rgb_in      (rgb_in),
      .test_en     (test_en),
      .pix_en      (pix_en),
      .x           (x),
      .y           (y),
      .active      (active),
      .line_start  (line_start),
      .frame_start (frame_start),
      .VGA_R       (VGA_R),
      .VGA_G       (VGA_G),
      .VGA_B       (VGA_B),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Source colour: a different value per pixel so misaligned capture shows.
   function automatic logic [11:0] src_of(input int hp, input int vp);
      logic [3:0] a, b, c;
      a = 4'(hp) ^ 4'h5;
      b = 4'(vp);
      c = 4'(hp >> 4);
      return {a, b, c};
   endfunction

   function automatic logic [11:0] exp_colour(input int hp, input int vp, input logic ten);
      if (hp >= 640 || vp >= VA) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
      if (ten) begin
         case (hp / 80)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
         endcase
      end
`endif
      return src_of(hp, vp);
   endfunction

   int   n;
   int   x656_n, hs_fall_n, y_vs_n, vs_fall_n, last_ls, last_fs;
   logic phs, pvs;
   logic [9:0] px, py;

   task automatic clear_trackers();
      x656_n = -1; hs_fall_n = -1; y_vs_n = -1; vs_fall_n = -1;
      last_ls = -1; last_fs = -1;
      phs = 1'b1; pvs = 1'b1; px = '0; py = '0;
   endtask

   task automatic step();
      int k, hp, vp, php, pvp;
      logic        pen, ehs, evs;
      logic [11:0] ecol;
      logic [37:0] obs, exp;
      @(posedge CLK100MHZ);
      n++;
      #1 rgb_in = src_of((n / 4) % HT, ((n / 4) / HT) % VT);
      @(negedge CLK100MHZ);
      k   = n / 4;
      hp  = k % HT;
      vp  = (k / HT) % VT;
      pen = ((n % 4) == 3);
      if (k == 0) begin
         ecol = 12'h000; ehs = 1'b1; evs = 1'b1;
      end else begin
         php  = (k - 1) % HT;
         pvp  = ((k - 1) / HT) % VT;
         ecol = exp_colour(php, pvp, test_en);
         ehs  = !(php >= 656 && php < 752);
         evs  = !(pvp >= VA + VFP && pvp < VA + VFP + VSW);
      end
      exp = {pen, pen && hp == 0, pen && hp == 0 && vp == 0, hp < 640 && vp < VA,
             10'(hp), 10'(vp), ecol, ehs, evs};
      obs = {pix_en, line_start, frame_start, active, x, y, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS};
      chk($sformatf("cyc%0d", n), 64'(obs), 64'(exp));

      if (x == 10'd656 && px != 10'd656) x656_n = n;
      if (y == 10'(VA + VFP) && py != 10'(VA + VFP)) y_vs_n = n;
      if (!VGA_HS && phs) begin
         chk("hs_fall_delay", 64'(n - x656_n), 64'd4);
         hs_fall_n = n;
      end
      if (VGA_HS && !phs && hs_fall_n >= 0) chk("hs_width", 64'(n - hs_fall_n), 64'd384);
      if (!VGA_VS && pvs) begin
         chk("vs_fall_delay", 64'(n - y_vs_n), 64'd4);
         vs_fall_n = n;
      end
      if (VGA_VS && !pvs && vs_fall_n >= 0) chk("vs_width", 64'(n - vs_fall_n), 64'd6400);
      if (line_start) begin
         if (last_ls >= 0) chk("line_period", 64'(n - last_ls), 64'(LINE_CLKS));
         last_ls = n;
      end
      if (frame_start) begin
         if (last_fs >= 0) chk("frame_period", 64'(n - last_fs), 64'(FRAME_CLKS));
         last_fs = n;
      end
      phs = VGA_HS; pvs = VGA_VS; px = x; py = y;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pins"},   64'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS}), 64'({12'h000, 1'b1, 1'b1}));
      chk({tag, "_xy"},     64'({x, y}), 64'd0);
      chk({tag, "_pix_en"}, 64'(pix_en), 64'd0);
      chk({tag, "_active"}, 64'(active), 64'd1);
      chk({tag, "_fstart"}, 64'(frame_start), 64'd0);
   endtask

   // Directed colour at pixels 0, 79, 80, 639 and blanked 640 of line 0.
`ifdef VGA_TEST_PATTERN_EN
   localparam logic [11:0] P0 = 12'hFFF, P79 = 12'hFFF, P80 = 12'hFF0, P639 = 12'h000;
`else
   localparam logic [11:0] P0 = 12'h500, P79 = 12'hA04, P80 = 12'h505, P639 = 12'hA07;
`endif

   initial begin
      clear_trackers();
      n = 0;
      CPU_RESETN = 1'b0;
      rgb_in     = 12'hFFF;
      test_en    = 1'b0;
      repeat (3) @(negedge CLK100MHZ);
      chk_reset_state("por");

      CPU_RESETN = 1'b1;
      // Two full frames plus up to (x=300, y=2) of the third.
      while (n < 4 * (HT * VT + 2 * HT + 300)) step();
      chk("mid_x", 64'(x), 64'd300);
      chk("mid_y", 64'(y), 64'd2);
      chk("mid_pins_lit", 64'({VGA_R, VGA_G, VGA_B}), 64'(src_of(299, 2)));

      // Asynchronous reset mid-line for three clocks.
      CPU_RESETN = 1'b0;
      #1;
      chk_reset_state("async");
      repeat (3) @(posedge CLK100MHZ);
      @(negedge CLK100MHZ);
      chk_reset_state("held");

      CPU_RESETN = 1'b1;
      n = 0;
      clear_trackers();
      test_en = 1'b1;
      repeat (3) step();
      chk("restart_fstart", 64'({frame_start, line_start, pix_en}), 64'b111);
      chk("restart_xy", 64'({x, y}), 64'd0);
      while (n < LINE_CLKS + 200) begin
         step();
         if (n == 4 * 1)   chk("pix0",   64'({VGA_R, VGA_G, VGA_B}), 64'(P0));
         if (n == 4 * 80)  chk("pix79",  64'({VGA_R, VGA_G, VGA_B}), 64'(P79));
         if (n == 4 * 81)  chk("pix80",  64'({VGA_R, VGA_G, VGA_B}), 64'(P80));
         if (n == 4 * 640) chk("pix639", 64'({VGA_R, VGA_G, VGA_B}), 64'(P639));
         if (n == 4 * 641) chk("pix640", 64'({VGA_R, VGA_G, VGA_B}), 64'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
